// File: rtl/snake_disp_pkg.sv
// Shared constants for the LED matrix / 7-segment display path:
// source encodings, the 7-segment pattern table and the row-scan state type.
package snake_disp_pkg;

  localparam logic SRC_GAME   = 1'b0;
  localparam logic SRC_BANNER = 1'b1;

  // Segments a..g,dp in bits 7..0, indexed by BCD value 0..9
  localparam logic [7:0] SEG7_TABLE [0:9] = '{
    8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110,
    8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110, 8'b11110110
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment pattern decoder; non-decimal codes are blanked.
module bcd_to_seg7
  import snake_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Table lookup for 0..9, dark for 10..15
  always_comb begin
    seg = 8'h00;
    if (bcd <= 4'd9) begin
      seg = SEG7_TABLE[bcd];
    end else begin
      seg = 8'h00;
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for the 8x8 red/green matrix and 6-digit 7-segment display.
// Output registers are loaded from next-state values so they line up with the state register.
module matrix_scan_ctrl
  import snake_disp_pkg::*;
#(
  parameter int ROW_CYCLES   = 8192,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src_sel,
  output logic        row_req,
  output logic [2:0]  row_idx,
  output logic        row_src,
  input  logic [7:0]  game_row_r,
  input  logic [7:0]  game_row_g,
  input  logic        game_row_vld,
  input  logic [7:0]  ban_row_r,
  input  logic [7:0]  ban_row_g,
  input  logic        ban_row_vld,
  input  logic [23:0] digits,
  output logic        frame_start,
  output logic        err_timeout,
  output logic [7:0]  matrix_segout_r,
  output logic [7:0]  matrix_segout_g,
  output logic [7:0]  matrix_scanout,
  output logic [7:0]  led_segout,
  output logic [2:0]  led_scanout
);

  localparam int            PW         = $clog2(ROW_CYCLES);
  localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] LAST_BLANK = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(ROW_CYCLES - 1);

  scan_state_t   state_r, state_s;
  logic [PW-1:0] phase_r, phase_s;
  logic [2:0]    row_r, row_s;
  logic          active_src_r, active_src_s;
  logic [23:0]   digit_r, digit_s;
  logic [7:0]    buf_red_r, buf_red_s;
  logic [7:0]    buf_grn_r, buf_grn_s;
  logic          cap_r, cap_s;
  logic          err_s;
  logic          req_s, frame_s;
  logic          sel_vld_s;
  logic [7:0]    sel_red_s, sel_grn_s;
  logic [3:0]    nibble_s;
  logic [7:0]    seg_s;

  assign row_idx = row_r;
  assign row_src = active_src_r;

  // Slot sequencing: IDLE -> BLANK -> DRIVE -> BLANK (next row)
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    row_s   = row_r;
    case (state_r)
      IDLE: begin
        state_s = BLANK;
        phase_s = PHASE_ZERO;
        row_s   = 3'd0;
      end
      BLANK: begin
        phase_s = phase_r + PW'(1);
        if (phase_r == LAST_BLANK) begin
          state_s = DRIVE;
        end else begin
          state_s = BLANK;
        end
      end
      DRIVE: begin
        if (phase_r == LAST_PHASE) begin
          state_s = BLANK;
          phase_s = PHASE_ZERO;
          row_s   = row_r + 3'd1;
        end else begin
          state_s = DRIVE;
          phase_s = phase_r + PW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        phase_s = PHASE_ZERO;
        row_s   = 3'd0;
      end
    endcase
  end

  // Frame-boundary latching and first-valid capture inside the blank window
  always_comb begin
    req_s        = (state_s == BLANK) && (phase_s == PHASE_ZERO);
    frame_s      = req_s && (row_s == 3'd0);
    active_src_s = active_src_r;
    digit_s      = digit_r;
    if (frame_s) begin
      active_src_s = src_sel;
      digit_s      = digits;
    end else begin
      active_src_s = active_src_r;
      digit_s      = digit_r;
    end

    if (active_src_r == SRC_BANNER) begin
      sel_vld_s = ban_row_vld;
      sel_red_s = ban_row_r;
      sel_grn_s = ban_row_g;
    end else begin
      sel_vld_s = game_row_vld;
      sel_red_s = game_row_r;
      sel_grn_s = game_row_g;
    end

    cap_s     = cap_r;
    buf_red_s = buf_red_r;
    buf_grn_s = buf_grn_r;
    err_s     = err_timeout;
    if ((state_r == BLANK) && (phase_r == PHASE_ZERO)) begin
      cap_s = 1'b0;
    end else if ((state_r == BLANK) && !cap_r && sel_vld_s) begin
      cap_s     = 1'b1;
      buf_red_s = sel_red_s;
      buf_grn_s = sel_grn_s;
    end else begin
      cap_s = cap_r;
    end

    // A row with no response is driven dark and flagged
    if ((state_r == BLANK) && (phase_r == LAST_BLANK) && !cap_s) begin
      buf_red_s = 8'h00;
      buf_grn_s = 8'h00;
      err_s     = 1'b1;
    end else begin
      err_s = err_timeout;
    end
  end

  // Digit slot follows the row counter; rows 6 and 7 have no digit
  always_comb begin
    nibble_s = 4'hF;
    case (row_s)
      3'd0:    nibble_s = digit_s[23:20];
      3'd1:    nibble_s = digit_s[19:16];
      3'd2:    nibble_s = digit_s[15:12];
      3'd3:    nibble_s = digit_s[11:8];
      3'd4:    nibble_s = digit_s[7:4];
      3'd5:    nibble_s = digit_s[3:0];
      default: nibble_s = 4'hF;
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (nibble_s),
    .seg (seg_s)
  );

  // State, capture buffer and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      phase_r         <= PHASE_ZERO;
      row_r           <= 3'd0;
      active_src_r    <= SRC_GAME;
      digit_r         <= 24'h000000;
      buf_red_r       <= 8'h00;
      buf_grn_r       <= 8'h00;
      cap_r           <= 1'b0;
      err_timeout     <= 1'b0;
      row_req         <= 1'b0;
      frame_start     <= 1'b0;
      matrix_scanout  <= 8'h00;
      matrix_segout_r <= 8'h00;
      matrix_segout_g <= 8'h00;
      led_segout      <= 8'h00;
      led_scanout     <= 3'd0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      row_r        <= row_s;
      active_src_r <= active_src_s;
      digit_r      <= digit_s;
      buf_red_r    <= buf_red_s;
      buf_grn_r    <= buf_grn_s;
      cap_r        <= cap_s;
      err_timeout  <= err_s;
      row_req      <= req_s;
      frame_start  <= frame_s;
      if (state_s == DRIVE) begin
        matrix_scanout  <= 8'b00000001 << row_s;
        matrix_segout_r <= buf_red_s;
        matrix_segout_g <= buf_grn_s;
      end else begin
        matrix_scanout  <= 8'h00;
        matrix_segout_r <= 8'h00;
        matrix_segout_g <= 8'h00;
      end
      if (row_s < 3'd6) begin
        led_scanout <= row_s;
        led_segout  <= seg_s;
      end else begin
        led_scanout <= 3'd0;
        led_segout  <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: per-row responses push the expected drive
// pattern, which is popped and compared when the row reaches its first DRIVE cycle.
module tb_matrix_scan_ctrl;

  localparam int RC = 16;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        src_sel = 1'b0;
  logic        row_req;
  logic [2:0]  row_idx;
  logic        row_src;
  logic [7:0]  game_row_r = 8'h00, game_row_g = 8'h00;
  logic        game_row_vld = 1'b0;
  logic [7:0]  ban_row_r = 8'h00, ban_row_g = 8'h00;
  logic        ban_row_vld = 1'b0;
  logic [23:0] digits = 24'h012A59;
  logic        frame_start;
  logic        err_timeout;
  logic [7:0]  matrix_segout_r, matrix_segout_g, matrix_scanout, led_segout;
  logic [2:0]  led_scanout;

  matrix_scan_ctrl #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .clk (clk), .reset (reset), .src_sel (src_sel),
    .row_req (row_req), .row_idx (row_idx), .row_src (row_src),
    .game_row_r (game_row_r), .game_row_g (game_row_g), .game_row_vld (game_row_vld),
    .ban_row_r (ban_row_r), .ban_row_g (ban_row_g), .ban_row_vld (ban_row_vld),
    .digits (digits), .frame_start (frame_start), .err_timeout (err_timeout),
    .matrix_segout_r (matrix_segout_r), .matrix_segout_g (matrix_segout_g),
    .matrix_scanout (matrix_scanout), .led_segout (led_segout), .led_scanout (led_scanout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] sb_q[$];
  logic        exp_src = 1'b0;
  logic [23:0] exp_dig = 24'h000000;
  logic        exp_err = 1'b0;
  int          exp_row = 0;
  int          last_fs = -1;
  int          rel_cyc = 0;
  bit          after_rst = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 8'b11111100;
      4'd1: return 8'b01100000;
      4'd2: return 8'b11011010;
      4'd3: return 8'b11110010;
      4'd4: return 8'b01100110;
      4'd5: return 8'b10110110;
      4'd6: return 8'b10111110;
      4'd7: return 8'b11100000;
      4'd8: return 8'b11111110;
      4'd9: return 8'b11110110;
      default: return 8'b00000000;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_scan"}, matrix_scanout, 0);
    check_eq({tag, "_segr"}, matrix_segout_r, 0);
    check_eq({tag, "_segg"}, matrix_segout_g, 0);
    check_eq({tag, "_req"}, row_req, 0);
    check_eq({tag, "_fs"}, frame_start, 0);
    check_eq({tag, "_err"}, err_timeout, 0);
    check_eq({tag, "_ledseg"}, led_segout, 0);
    check_eq({tag, "_ledscan"}, led_scanout, 0);
    check_eq({tag, "_row"}, row_idx, 0);
    check_eq({tag, "_src"}, row_src, 0);
  endtask

  // gd/gd2: BLANK cycles with a game vld (second one carries alternate data);
  // bd: BLANK cycle with a banner vld; -1 means none.
  task automatic scan_row(input int gd, input int gd2, input int bd, input bit do_rst);
    int n;
    bit tmo;
    logic [7:0] gr, gg, ar, ag, br, bg, er, eg, escan;
    logic [23:0] e;
    n = 0;
    while (row_req !== 1'b1 && n < 3 * RC) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", row_req, 1);
    check_eq("row_idx", row_idx, exp_row);
    if (exp_row == 0) begin
      exp_src = src_sel;
      exp_dig = digits;
      check_eq("frame_start", frame_start, 1);
      if (after_rst) check_eq("fs_after_reset", cyc - rel_cyc, 1);
      else if (last_fs >= 0) check_eq("fs_spacing", cyc - last_fs, 8 * RC);
      last_fs = cyc;
      after_rst = 1'b0;
    end else begin
      check_eq("frame_start", frame_start, 0);
    end
    check_eq("row_src", row_src, exp_src);
    check_eq("blank_scan", matrix_scanout, 0);
    check_eq("blank_seg", {matrix_segout_r, matrix_segout_g}, 0);
    check_eq("err_pre", err_timeout, exp_err);
    if (exp_row < 6) begin
      check_eq("led_scan", led_scanout, exp_row);
      check_eq("led_seg", led_segout, seg_ref(exp_dig[(5 - exp_row) * 4 +: 4]));
    end else begin
      check_eq("led_scan", led_scanout, 0);
      check_eq("led_seg", led_segout, 0);
    end

    gr = 8'h80 >> exp_row;  gg = 8'h01;
    ar = ~gr;               ag = 8'hAA;
    br = 8'h01 << exp_row;  bg = 8'hF0;
    escan = 8'h01 << exp_row;
    tmo = 1'b0;
    er = 8'h00;
    eg = 8'h00;
    if (exp_src == 1'b0) begin
      if (gd >= 1 && gd <= BC - 1) begin er = gr; eg = gg; end
      else if (gd2 >= 1 && gd2 <= BC - 1) begin er = ar; eg = ag; end
      else tmo = 1'b1;
    end else begin
      if (bd >= 1 && bd <= BC - 1) begin er = br; eg = bg; end
      else tmo = 1'b1;
    end
    sb_q.push_back({escan, er, eg});

    for (int k = 0; k < BC; k++) begin
      if (k > 0) @(negedge clk);
      game_row_vld = (k == gd) || (k == gd2);
      game_row_r   = (k == gd2) ? ar : gr;
      game_row_g   = (k == gd2) ? ag : gg;
      ban_row_vld  = (k == bd);
      ban_row_r    = br;
      ban_row_g    = bg;
      if (k == 1) begin
        check_eq("req_pulse", row_req, 0);
        check_eq("err_in_blank", err_timeout, exp_err);
      end
    end
    @(negedge clk);
    game_row_vld = 1'b0;
    ban_row_vld  = 1'b0;
    exp_err = exp_err | tmo;
    check_eq("sb_depth", sb_q.size(), 1);
    e = sb_q.pop_front();
    check_eq("drive_scan", matrix_scanout, e[23:16]);
    check_eq("drive_segr", matrix_segout_r, e[15:8]);
    check_eq("drive_segg", matrix_segout_g, e[7:0]);
    check_eq("err_post", err_timeout, exp_err);

    if (do_rst) begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_eq("idle_fs", frame_start, 0);
      rel_cyc = cyc;
      after_rst = 1'b1;
      exp_row = 0;
      exp_err = 1'b0;
      last_fs = -1;
      sb_q.delete();
      return;
    end

    // Late vlds during DRIVE must not disturb the row
    repeat (2) @(negedge clk);
    game_row_vld = 1'b1; ban_row_vld = 1'b1;
    game_row_r = 8'h5A; game_row_g = 8'h5A; ban_row_r = 8'h5A; ban_row_g = 8'h5A;
    @(negedge clk);
    game_row_vld = 1'b0; ban_row_vld = 1'b0;
    repeat (RC - 1 - (BC + 3)) @(negedge clk);
    check_eq("drive_end_scan", matrix_scanout, e[23:16]);
    check_eq("drive_end_seg", {matrix_segout_r, matrix_segout_g}, e[15:0]);
    @(negedge clk);
    check_eq("next_blank_scan", matrix_scanout, 0);
    exp_row = (exp_row + 1) % 8;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    rel_cyc = cyc;
    after_rst = 1'b1;

    // Basic scan, game source, digits 01 2A 59
    for (int r = 0; r < 8; r++) scan_row(2, -1, 2, 1'b0);
    // Request banner and change digits mid-frame
    for (int r = 0; r < 3; r++) scan_row(2, -1, 2, 1'b0);
    src_sel = 1'b1;
    digits  = 24'h987654;
    for (int r = 3; r < 8; r++) scan_row(2, -1, 2, 1'b0);
    // Banner frame with a missing row 5 response
    for (int r = 0; r < 5; r++) scan_row(2, -1, 2, 1'b0);
    scan_row(2, -1, -1, 1'b0);
    src_sel = 1'b0;
    scan_row(2, -1, 2, 1'b0);
    scan_row(2, -1, 2, 1'b0);
    // Window edges on the game source, then reset during row 4 DRIVE
    scan_row(0, -1, 2, 1'b0);
    scan_row(3, -1, 2, 1'b0);
    scan_row(1, 2, 2, 1'b0);
    scan_row(2, -1, 2, 1'b0);
    scan_row(2, -1, 2, 1'b1);
    // Clean frame after reset
    for (int r = 0; r < 8; r++) scan_row(2, -1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
